// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down sweep controller.
package updown_pkg;

    // Controller states: idle, counting towards hi, counting towards lo.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    // Direction encoding on the counter's up input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updown_counter_sync.sv
// Synchronous up/down counter with synchronous load and count enable.
module updown_counter_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             t,
    input  logic             up,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: load wins over counting; hold when t is low.
    always_comb begin
        // NOTE: default first so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (t) begin
            q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
        end
    end

    // Count register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for flops so all registers update together.
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: drives an up/down counter back and forth between
// latched limits lo and hi for a programmed number of sweeps (0 = forever).
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    output logic               t,
    output logic               up,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [SWEEP_W-1:0]   sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 load;
    logic [WIDTH-1:0]     din;

    logic at_hi;
    logic at_lo;
    logic last_sweep;
    logic start_ok;

    assign at_hi      = (q == hi_q);
    assign at_lo      = (q == lo_q);
    // Completing this sweep reaches a nonzero programmed count.
    assign last_sweep = (sweeps_q != '0) && ((cnt_q + SWEEP_W'(1)) == sweeps_q);
    assign start_ok   = (lo < hi);

    // State, latched limits, sweep counter and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            sweeps_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sweeps_q <= sweeps_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next state: stop beats pause, pause defers the limit decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && start_ok) state_d = UP;
            end
            UP: begin
                if (stop)                state_d = IDLE;
                else if (!pause && at_hi) state_d = DOWN;
            end
            DOWN: begin
                if (stop)                state_d = IDLE;
                else if (!pause && at_lo) state_d = last_sweep ? IDLE : UP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Start acceptance/rejection, sweep counting and done/err pulses.
    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        sweeps_d = sweeps_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        din      = lo;
        if (state_q == IDLE && start) begin
            if (start_ok) begin
                lo_d     = lo;
                hi_d     = hi;
                sweeps_d = sweeps;
                cnt_d    = '0;
                load     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (state_q == DOWN && !stop && !pause && at_lo) begin
            cnt_d  = cnt_q + SWEEP_W'(1);
            done_d = last_sweep;
        end
        busy_d = (state_d != IDLE);
    end

    // Counter controls decoded from state, position, pause and stop.
    always_comb begin
        t  = 1'b0;
        up = DIR_UP;
        case (state_q)
            UP: begin
                up = at_hi ? DIR_DN : DIR_UP;
                t  = !stop && !pause;
            end
            DOWN: begin
                up = at_lo ? DIR_UP : DIR_DN;
                t  = !stop && !pause && !(at_lo && last_sweep);
            end
            default: begin
                t  = 1'b0;
                up = DIR_UP;
            end
        endcase
    end

    updown_counter_sync #(.WIDTH(WIDTH)) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .t    (t),
        .up   (up),
        .q    (q)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl against a triangle-wave model.
module tb_updown_sweep_ctrl;

    localparam int WIDTH   = 2;
    localparam int SWEEP_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, stop, pause;
    logic [WIDTH-1:0]   lo, hi;
    logic [SWEEP_W-1:0] sweeps;
    logic               t, up, busy, done, err;
    logic [WIDTH-1:0]   q;

    int checks   = 0;
    int failures = 0;

    // Reference model: a run is a step index into a triangle wave.
    bit m_run, m_done, m_err;
    int m_lo, m_hi, m_sw, m_steps, m_q;

    updown_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
        .clk(clk), .rst(rst_n), .start(start), .stop(stop), .pause(pause),
        .lo(lo), .hi(hi), .sweeps(sweeps), .t(t), .up(up), .q(q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int tri_pos(int s);
        int d, m;
        d = m_hi - m_lo;
        m = s % (2 * d);
        return (m <= d) ? m : 2 * d - m;
    endfunction

    function automatic bit m_at_end();
        return m_run && (m_sw != 0) && (m_steps == 2 * (m_hi - m_lo) * m_sw);
    endfunction

    function automatic bit m_t();
        return m_run && !stop && !pause && !m_at_end();
    endfunction

    function automatic bit m_up();
        int d;
        if (!m_run) return 1'b1;
        d = m_hi - m_lo;
        return (m_steps % (2 * d)) < d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_err = 0;
        m_lo = 0; m_hi = 0; m_sw = 0; m_steps = 0; m_q = 0;
    endtask

    task automatic model_update();
        bit fin;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (!m_run) begin
            if (start) begin
                if (int'(lo) < int'(hi)) begin
                    m_run = 1; m_lo = lo; m_hi = hi; m_sw = sweeps;
                    m_steps = 0; m_q = lo;
                end else begin
                    m_err = 1;
                end
            end
        end else if (stop) begin
            m_run = 0;
        end else if (!pause) begin
            fin = m_at_end();
            if (fin) begin
                m_run = 0; m_done = 1;
            end else begin
                m_steps++;
                m_q = m_lo + tri_pos(m_steps);
            end
        end
    endtask

    // One clock: compare all outputs at the falling edge, then advance the model.
    task automatic run_cycle();
        @(negedge clk);
        checks++; if (q !== WIDTH'(m_q)) begin failures++; $display("FAIL q: got %0d want %0d", q, m_q); end
        checks++; if (busy !== m_run) begin failures++; $display("FAIL busy: got %0b want %0b", busy, m_run); end
        checks++; if (done !== m_done) begin failures++; $display("FAIL done: got %0b want %0b", done, m_done); end
        checks++; if (err !== m_err) begin failures++; $display("FAIL err: got %0b want %0b", err, m_err); end
        checks++; if (t !== m_t()) begin failures++; $display("FAIL t: got %0b want %0b", t, m_t()); end
        if (!m_run || m_t()) begin
            checks++; if (up !== m_up()) begin failures++; $display("FAIL up: got %0b want %0b", up, m_up()); end
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; stop = 0; pause = 0; lo = '0; hi = '0; sweeps = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            begin failures++; $display("FAIL reset_regs: q=%0d busy=%0b done=%0b err=%0b want 0", q, busy, done, err); end
        checks++; if (t !== 1'b0 || up !== 1'b1)
            begin failures++; $display("FAIL reset_ctl: t=%0b up=%0b want t=0 up=1", t, up); end
        rst_n = 1'b1;
        repeat (2) run_cycle();
    endtask

    // Accept a run and compare q after each edge plus the done edge index.
    task automatic check_sequence(string name, int l, int h, int s, int exp_q[$], int exp_done);
        int done_at = -1;
        lo = WIDTH'(l); hi = WIDTH'(h); sweeps = SWEEP_W'(s); start = 1;
        run_cycle();
        start = 0;
        for (int k = 0; k < exp_done + 3; k++) begin
            if (k < exp_q.size()) begin
                checks++; if (q !== WIDTH'(exp_q[k]))
                    begin failures++; $display("FAIL %s_q[%0d]: got %0d want %0d", name, k, q, exp_q[k]); end
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
            run_cycle();
        end
        checks++; if (done_at != exp_done)
            begin failures++; $display("FAIL %s_done_at: got %0d want %0d", name, done_at, exp_done); end
        checks++; if (q !== WIDTH'(l) || busy !== 1'b0)
            begin failures++; $display("FAIL %s_end: q=%0d busy=%0b want q=%0d busy=0", name, q, busy, l); end
    endtask

    task automatic test_single_sweep();
        check_sequence("single", 0, 3, 1, '{0, 1, 2, 3, 2, 1, 0}, 7);
    endtask

    task automatic test_two_sweeps();
        check_sequence("two", 1, 2, 2, '{1, 2, 1, 2, 1}, 5);
    endtask

    task automatic test_reject();
        logic [WIDTH-1:0] q_before;
        q_before = q;
        lo = 2; hi = 2; sweeps = 1; start = 1;
        run_cycle();
        start = 0;
        checks++; if (err !== 1'b1 || busy !== 1'b0 || q !== q_before)
            begin failures++; $display("FAIL reject: err=%0b busy=%0b q=%0d want err=1 busy=0 q=%0d", err, busy, q, q_before); end
        run_cycle();
        checks++; if (err !== 1'b0)
            begin failures++; $display("FAIL reject_pulse: err=%0b want 0", err); end
    endtask

    task automatic test_continuous();
        int dones = 0;
        lo = 0; hi = 3; sweeps = 0; start = 1;
        run_cycle();
        start = 0;
        for (int k = 0; k < 24; k++) begin
            if (done === 1'b1) dones++;
            run_cycle();
        end
        checks++; if (dones != 0 || busy !== 1'b1)
            begin failures++; $display("FAIL cont_run: dones=%0d busy=%0b want 0/1", dones, busy); end
        for (int k = 0; k < 8 && m_q != 2; k++) run_cycle();
        stop = 1;
        run_cycle();
        stop = 0;
        checks++; if (busy !== 1'b0 || q !== 2 || done !== 1'b0)
            begin failures++; $display("FAIL cont_stop: busy=%0b q=%0d done=%0b want 0/2/0", busy, q, done); end
        repeat (3) run_cycle();
        checks++; if (q !== 2)
            begin failures++; $display("FAIL cont_hold: q=%0d want 2", q); end
    endtask

    task automatic test_pause();
        int done_at = -1;
        lo = 0; hi = 3; sweeps = 1; start = 1;
        run_cycle();
        start = 0;
        for (int k = 0; k < 14; k++) begin
            pause = (k >= 3 && k < 6);
            if (k >= 4 && k <= 6) begin
                checks++; if (q !== 3)
                    begin failures++; $display("FAIL pause_q[%0d]: got %0d want 3", k, q); end
            end
            if (pause) begin
                #1;
                checks++; if (t !== 1'b0)
                    begin failures++; $display("FAIL pause_t[%0d]: got %0b want 0", k, t); end
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
            run_cycle();
        end
        pause = 0;
        checks++; if (done_at != 10)
            begin failures++; $display("FAIL pause_done_at: got %0d want 10", done_at); end
    endtask

    task automatic test_reset_mid_run();
        lo = 0; hi = 3; sweeps = 0; start = 1;
        run_cycle();
        start = 0;
        repeat (2) run_cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (q !== 0 || busy !== 1'b0 || t !== 1'b0)
            begin failures++; $display("FAIL rst_mid: q=%0d busy=%0b t=%0b want 0/0/0", q, busy, t); end
        run_cycle();
        rst_n = 1'b1;
        lo = 1; hi = 3; sweeps = 1; start = 1;
        run_cycle();
        start = 0;
        checks++; if (q !== 1 || busy !== 1'b1)
            begin failures++; $display("FAIL rst_restart: q=%0d busy=%0b want 1/1", q, busy); end
        repeat (10) run_cycle();
    endtask

    task automatic test_back_to_back();
        // start with stop in IDLE is accepted; stop alone in IDLE is ignored
        stop = 1; run_cycle();
        lo = 0; hi = 1; sweeps = 2; start = 1;
        run_cycle();
        stop = 0;
        checks++; if (busy !== 1'b1)
            begin failures++; $display("FAIL start_stop: busy=%0b want 1", busy); end
        // start and new limits while busy are ignored
        lo = 2; hi = 3; sweeps = 9;
        repeat (8) run_cycle();
        start = 0;
        repeat (2) run_cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 5) == 0);
            if (!m_run || $urandom_range(0, 7) == 0) begin
                lo     = WIDTH'($urandom_range(0, 3));
                hi     = WIDTH'($urandom_range(0, 3));
                sweeps = SWEEP_W'($urandom_range(0, 3));
            end
            run_cycle();
        end
        start = 0; pause = 0; stop = 1;
        repeat (2) run_cycle();
        stop = 0;
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_two_sweeps();
        test_reject();
        test_continuous();
        test_pause();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencing controller for the team's up/down counter datapath. Drives the counter's `t` (count enable) and `up` (direction) controls so the count sweeps back and forth between programmable limits `lo` and `hi` for a programmed number of sweeps, or continuously. It provides start, pause and stop controls, plus busy, done and error status. It sits between the system control logic and a local synchronous up/down counter instance, and exports the count value.

## Interface
Parameters:
- `WIDTH`, default 2, counter width in bits.
- `SWEEP_W`, default 8, width of the sweep-count register.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `stop`, in, 1: abort the current run.
- `pause`, in, 1: freeze counting while high.
- `lo`, in, WIDTH: lower limit, unsigned.
- `hi`, in, WIDTH: upper limit, unsigned.
- `sweeps`, in, SWEEP_W: number of lo→hi→lo sweeps; 0 means continuous.
- `t`, out, 1: count enable to the counter.
- `up`, out, 1: direction; 1 is up, 0 is down.
- `q`, out, WIDTH: current count.
- `busy`, out, 1: high while in UP or DOWN.
- `done`, out, 1: one-cycle pulse when the programmed sweeps complete.
- `err`, out, 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, UP, DOWN.
- `lo`, `hi` and `sweeps` are latched on an accepted start. Later changes are ignored until the next start.
- IDLE:
  - `t`=0, `up`=1, `q` holds.
  - `start` with `lo`<`hi`: load `q`=`lo`, clear the sweep counter, go to UP.
  - `start` with `lo`>=`hi`: stay in IDLE, pulse `err`; `q` unchanged.
- UP, `t`=1:
  - `q`≠hi: `up`=1, increment.
  - `q`==hi: `up`=0, decrement on the same edge, go to DOWN. `hi` is held for exactly one cycle.
- DOWN, `t`=1:
  - `q`≠lo: `up`=0, decrement.
  - `q`==lo: increment the sweep counter.
    - Count now equals a nonzero `sweeps`: `t`=0, go to IDLE, pulse `done`; `q` stays at lo.
    - Otherwise: `up`=1, increment, go to UP.
- `pause` high in UP or DOWN: `t`=0, state and sweep counter frozen. The limit decision is deferred until `pause` falls.
- `stop` high in UP or DOWN: `t`=0, go to IDLE next edge. `q` is retained; no `done` pulse.
- Priority: `stop` > `pause` > limit logic.
- `start` while busy: ignored.
- `stop` in IDLE: ignored.
- `start` and `stop` together in IDLE: `start` is accepted.
- Continuous mode (`sweeps`=0): the sweep counter wraps and is never compared; the run ends only on `stop`.
- Arithmetic is unsigned WIDTH-bit. Limits guarantee no wrap of `q` during a run.
- Reset (asynchronous, any state):
  - State IDLE, `q`=0, sweep counter=0, latched limits=0.
  - Outputs: `t`=0, `up`=1, `busy`=0, `done`=0, `err`=0.
  - Reset mid-run abandons the run immediately.

## Timing
- All outputs are registered except `t` and `up`, which are decoded combinationally from state, `q`, `pause` and `stop`.
- Accepting edge E0: `q`=lo and `busy`=1 from E0.
- Sweep period is 2·(hi−lo) cycles. The final decision edge is E0 + 2·(hi−lo)·sweeps + 1.
- `done` is high for the one cycle after the final edge, coincident with `busy` falling.
- `err` is high for the one cycle after the rejecting edge.
- Each cycle of `pause` adds exactly one cycle of latency.

## Structure
- Package `updown_pkg`:
  - State enum (IDLE, UP, DOWN).
  - Direction constants `DIR_UP`=1 and `DIR_DN`=0.
- Sub-module `updown_counter_sync`, parameter WIDTH:
  - Ports `clk`, `rst` (active-low asynchronous), `load`, `din`, `t`, `up`, `q`.
  - Synchronous load; count when `t` is high.
- The controller holds the FSM, the latched limits and the sweep counter.

## Test plan
- WIDTH=2, lo=0, hi=3, sweeps=1:
  - `q` runs 0,1,2,3,2,1,0.
  - `done` is high exactly 7 cycles after the accepting edge.
  - Final `q`=0, `busy`=0.
- lo=1, hi=2, sweeps=2: `q` runs 1,2,1,2,1, then `done` with `q`=1.
- lo=2, hi=2, start: `err` pulses once; `busy` stays 0; `q` unchanged.
- sweeps=0, lo=0, hi=3:
  - Triangle wave persists beyond 20 cycles with no `done`.
  - `stop` at `q`=2 gives IDLE with `q`=2 held.
- `pause` held 3 cycles at `q`=hi during UP: `t`=0, `q`=hi frozen, then DOWN resumes; `done` is delayed by exactly 3 cycles.
- Reset asserted mid-run at `q`=2:
  - Immediately `q`=0, `busy`=0, `t`=0.
  - After release, `start` begins cleanly from `lo`.
